// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with exception/iret redirect FSM, drain window and double-fault halt
// Optional same-cycle forwarding outputs are enabled by defining WB_STAGE_BYPASS_EN.
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_2000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] result,
    input  logic [31:0] readData,
    input  logic [4:0]  rd,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic        exception,
    input  logic [31:0] faulty_address,
    input  logic [31:0] pc,
    input  logic        iret,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] rm0,
    output logic [31:0] rm1,
    output logic        supervisor,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        halted
`ifdef WB_STAGE_BYPASS_EN
    ,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [31:0] byp_data
`endif
);

    typedef enum logic [1:0] {RUN, TRAP, DRAIN, HALT} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // iret from user mode is a no-op; exception always wins over iret
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (exception) begin
                    state_next = supervisor ? HALT : TRAP;
                end else if (iret && supervisor) begin
                    state_next = TRAP;
                end
            end
            TRAP:    state_next = DRAIN;
            DRAIN:   state_next = (count == 4'd0) ? RUN : DRAIN;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        redirect = 1'b0;
        flush    = 1'b0;
        halted   = 1'b0;
        case (state)
            TRAP: begin
                redirect = 1'b1;
                flush    = 1'b1;
            end
            DRAIN: flush = 1'b1;
            HALT: begin
                flush  = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count       <= 4'd0;
            rm0         <= 32'd0;
            rm1         <= 32'd0;
            supervisor  <= 1'b1;
            redirect_pc <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (exception) begin
                        if (!supervisor) begin
                            rm0         <= pc;
                            rm1         <= faulty_address;
                            supervisor  <= 1'b1;
                            redirect_pc <= EXC_VECTOR;
                        end
                    end else if (iret && supervisor) begin
                        supervisor  <= 1'b0;
                        redirect_pc <= rm0;
                    end
                end
                TRAP:  count <= 4'(DRAIN_CYCLES - 1);
                DRAIN: if (count != 4'd0) count <= count - 4'd1;
                default: ;
            endcase
        end
    end

    assign rf_wdata = memToReg ? readData : result;
    assign rf_waddr = rd;
    assign rf_we    = (state == RUN) && regWrite && (rd != 5'd0) && !exception && !iret;

`ifdef WB_STAGE_BYPASS_EN
    assign byp_valid = rf_we;
    assign byp_rd    = rf_waddr;
    assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage against a cycle-count reference model
module tb_wb_stage;

    localparam logic [31:0] EXC = 32'h0000_2000;
    localparam int          DRN = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] result = '0, readData = '0, faulty_address = '0, pc = '0;
    logic [4:0]  rd = '0;
    logic        memToReg = 0, regWrite = 0, exception = 0, iret = 0;
    logic        rf_we, supervisor, redirect, flush, halted;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rm0, rm1, redirect_pc;

    wb_stage #(.EXC_VECTOR(EXC), .DRAIN_CYCLES(DRN)) dut (
        .clock(clock), .reset_n(reset_n), .result(result), .readData(readData),
        .rd(rd), .memToReg(memToReg), .regWrite(regWrite), .exception(exception),
        .faulty_address(faulty_address), .pc(pc), .iret(iret),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rm0(rm0), .rm1(rm1),
        .supervisor(supervisor), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata, m0, m1, rpc;
        logic        sup, rdr, fl, hlt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: busy counts remaining flush cycles after a redirect (TRAP + drain window)
    int          m_busy;
    bit          m_halt, m_sup;
    logic [31:0] m_rm0, m_rm1, m_rpc;

    function automatic void model_reset();
        m_busy = 0; m_halt = 0; m_sup = 1;
        m_rm0 = 0; m_rm1 = 0; m_rpc = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit rw, input bit m2r, input logic [4:0] r, input logic [31:0] res,
                         input logic [31:0] ld, input bit exc, input logic [31:0] fa,
                         input logic [31:0] p, input bit ir);
        exp_t e;
        @(posedge clock);
        #1;
        regWrite = rw; memToReg = m2r; rd = r; result = res; readData = ld;
        exception = exc; faulty_address = fa; pc = p; iret = ir;
        e.we    = !m_halt && m_busy == 0 && rw && r != 0 && !exc && !ir;
        e.waddr = r;
        e.wdata = m2r ? ld : res;
        e.m0 = m_rm0; e.m1 = m_rm1; e.rpc = m_rpc; e.sup = m_sup;
        e.rdr = (m_busy == DRN + 1);
        e.fl  = m_halt || m_busy > 0;
        e.hlt = m_halt;
        exp_q.push_back(e);
        if (!m_halt) begin
            if (m_busy > 0) begin
                m_busy--;
            end else if (exc) begin
                if (m_sup) m_halt = 1;
                else begin
                    m_rm0 = p; m_rm1 = fa; m_sup = 1; m_rpc = EXC; m_busy = DRN + 1;
                end
            end else if (ir && m_sup) begin
                m_sup = 0; m_rpc = m_rm0; m_busy = DRN + 1;
            end
        end
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 0;
        regWrite = 0; memToReg = 0; rd = 0; result = 0; readData = 0;
        exception = 0; faulty_address = 0; pc = 0; iret = 0;
        #1;
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect, 0);
        check("rst_halted", halted, 0);
        check("rst_supervisor", supervisor, 1);
        check("rst_rm0", rm0, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        model_reset();
        @(negedge clock);
        #1;
        reset_n = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", rf_we, e.we);
                check("rf_waddr", rf_waddr, e.waddr);
                check("rf_wdata", rf_wdata, e.wdata);
                check("rm0", rm0, e.m0);
                check("rm1", rm1, e.m1);
                check("supervisor", supervisor, e.sup);
                check("redirect", redirect, e.rdr);
                check("redirect_pc", redirect_pc, e.rpc);
                check("flush", flush, e.fl);
                check("halted", halted, e.hlt);
            end
        end
    end

    initial begin : stimulus
        int halt_cycles;
        model_reset();
        #12 reset_n = 1;
        bubble(1);
        // Write path: load data, rd=0 suppression, ALU result select
        cycle(1, 1, 5, 32'h1, 32'hCAFE0001, 0, 0, 0, 0);
        cycle(1, 1, 0, 32'h1, 32'hCAFE0001, 0, 0, 0, 0);
        cycle(1, 0, 7, 32'h1234_5678, 32'hDEAD, 0, 0, 0, 0);
        // iret from supervisor, then user-mode fault
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        bubble(DRN + 1);
        cycle(0, 0, 0, 0, 0, 1, 32'h8000, 32'h400, 0);
        for (int i = 0; i < DRN + 1; i++) cycle(1, 0, 3, 32'h55, 0, 0, 0, 0, 0);
        cycle(1, 0, 3, 32'h66, 0, 0, 0, 0, 0);
        // return to user, iret in user mode is a no-op, then simultaneous exception+iret
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        bubble(DRN + 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 32'h9000, 32'h500, 1);
        bubble(DRN + 1);
        // double fault
        cycle(0, 0, 0, 0, 0, 1, 32'hA000, 32'h600, 0);
        cycle(1, 0, 9, 32'h77, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'hB000, 32'h700, 1);
        cycle(1, 1, 9, 32'h77, 32'h88, 0, 0, 0, 1);
        // reset during DRAIN cycle 2
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        bubble(2);
        do_reset();
        cycle(1, 0, 4, 32'hABCD, 0, 0, 0, 0, 0);
        // randomized phase
        halt_cycles = 0;
        for (int n = 0; n < 400; n++) begin
            if (m_halt) halt_cycles++;
            if (halt_cycles > 6 || $urandom_range(0, 99) == 0) begin
                halt_cycles = 0;
                do_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                bubble(1);
            end else begin
                cycle($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                      $urandom, $urandom, $urandom_range(0, 11) == 0, $urandom, $urandom,
                      $urandom_range(0, 5) == 0);
            end
        end
        @(negedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
